seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
Parametrised time-multiplexed 7-segment display controller that scans NUM_DIGITS hex digits.
- Adds per-digit decimal points, 16-level PWM brightness, leading-zero blanking and a ghost-suppression guard interval.
- Loads display data only on a chip-select strobe, so a bus-mapped register can drive it.
- Sits between the CPU's memory-mapped I/O and the board's common-anode display pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned; legal range 1..16.
SCAN_DIV_LOG2, 15, log2 of CLK cycles per digit slot; legal range >= 5.
BLINK_LOG2, 6, log2 of scan frames per blink half-period; used only with SEG7_BLINK_EN.

Ports:
CLK  in  1  system clock
reset  in  1  asynchronous, active-high reset
cs  in  1  load strobe; latches i_data and i_dp
i_data  in  4*NUM_DIGITS  hex nibbles; digit k = i_data[4k+3:4k]
i_dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
i_bright  in  4  brightness; 0 = off, 15 = maximum
i_blank_lz  in  1  1 = blank leading zero digits
o_seg  out  8  active-low segments; bit 7 = DP, bits 6:0 = g..a
o_sel  out  NUM_DIGITS  active-low digit enables

Behaviour:
Reset values (asynchronous):
- o_seg = 8'hFF; o_sel = all ones.
- Internal state: prescaler cnt = 0, digit index = 0, data latch = 0, dp latch = 0.

Prescaler and digit index:
- cnt is SCAN_DIV_LOG2 bits wide, increments every CLK and wraps naturally.
- tick = (cnt == all ones). On tick the digit index increments; index NUM_DIGITS-1 wraps to 0.
- NUM_DIGITS need not be a power of two.

Load:
- When cs = 1 at a CLK edge, i_data and i_dp are latched into data_q and dp_q.
- The new value is visible on o_seg one cycle later if that digit is current.
- cs coinciding with tick: the index advances and the data loads in the same edge; no special case.

Phase and brightness:
- phase = cnt[SCAN_DIV_LOG2-1 -: 4].
- A digit is lit when 1 <= phase <= i_bright.
- Phase 0 is a guard interval and is always dark (ghost suppression).
- Duty per slot = i_bright/16. i_bright = 0 keeps o_sel all ones permanently.
- i_bright is sampled live, not latched.

Leading-zero blanking:
- With i_blank_lz = 1, digit k is blanked when every nibble from k up to NUM_DIGITS-1 in data_q is 0, for k >= 1.
- Digit 0 is never blanked by this rule.
- A blanked digit keeps its o_sel bit high for the whole slot.

Font (nibble -> o_seg[6:0] plus bit 7 = 1):
- 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
- 8:80, 9:90, A:88, B:83, C:C6, D:A1, E:86, F:8E
- o_seg[7] = ~dp_q[index].

Output registers:
- o_seg and o_sel are both registered from the same-cycle index, cnt, data_q and dp_q values.
- They therefore change on the same edge: latency 1 CLK, no skew.
- When o_sel is all ones, o_seg still carries the current digit's code.

Reset mid-scan: outputs return to reset values immediately; scanning restarts at digit 0, cnt 0.

Optional Feature:
SEG7_BLINK_EN:
- Defined:
  - Adds input i_blink [NUM_DIGITS-1:0].
  - A BLINK_LOG2-bit frame counter increments on each index wrap (NUM_DIGITS-1 -> 0) and resets to 0.
  - Digits with i_blink[k] = 1 are dark while the frame counter MSB = 1.
- Undefined: no i_blink port, no frame counter, no blinking.

Decomposition:
- Package seg7_pkg holds:
  - SEG_OFF = 8'hFF;
  - the 16-entry font constant;
  - a function hex_to_seg(nibble) returning 7 bits.
- One sub-module, seg7_lz_blank: combinational, data_q -> NUM_DIGITS blank mask.
- Scan, PWM and output registers stay in the top module.

Test Plan:
Bench parameters: NUM_DIGITS = 4, SCAN_DIV_LOG2 = 5 (32 cycles per slot, 2 cycles per phase).
1. Reset and blank start:
   - Hold reset for 3 cycles -> o_seg = FF, o_sel = 4'hF.
   - After release with data 0 and i_bright = 15 -> o_sel = 1110 from cycle 3 (cnt = 2 sampled), o_seg = C0.
2. Load and scan order:
   - cs pulse with i_data = 16'h1A2F, i_bright = 15.
   - Digit 0 -> 8E/1110, digit 1 -> A4/1101, digit 2 -> 88/1011, digit 3 -> F9/0111.
   - Each digit lit 30 of 32 cycles; wrap from digit 3 to digit 0.
3. Brightness:
   - i_bright = 3 -> each slot lit exactly 6 cycles (cnt 2..7).
   - i_bright = 0 -> o_sel = 4'hF for a full frame.
4. Leading-zero blanking with i_blank_lz = 1:
   - Data 16'h0050 -> digits 3 and 2 never selected; digit 1 = 92, digit 0 = C0.
   - Data 16'h0000 -> only digit 0 lit, showing C0.
5. Decimal point and simultaneous load:
   - i_dp = 4'b0100 -> digit 2 o_seg[7] = 0, all other digits 1.
   - cs asserted on the tick edge -> the next slot shows the new data immediately.
6. Mid-scan reset and blink:
   - Assert reset during digit 2 -> FF/all ones in the same cycle; after release the scan restarts at digit 0.
   - With SEG7_BLINK_EN, BLINK_LOG2 = 2, i_blink = 0001 -> digit 0 dark in frames 2 and 3, lit in frames 0 and 1.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: blank code and hex font.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low codes with bit 7 (DP) high; index 15 is leftmost.
    localparam logic [15:0][7:0] FONT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return FONT[nibble][6:0];
    endfunction

endpackage

// File: rtl/seg7_lz_blank.sv
// Leading-zero blank mask: digit k (k >= 1) is blanked when it and every
// more-significant nibble are zero. Purely combinational.
module seg7_lz_blank #(
    parameter int NUM_DIGITS = 8
) (
    input  logic [4*NUM_DIGITS-1:0] data_i,
    output logic [NUM_DIGITS-1:0]   blank_o
);

    logic upper_zero;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        upper_zero = 1'b1;
        blank_o    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (data_i[4*k +: 4] == 4'h0);
            if (k != 0) begin
                blank_o[k] = upper_zero;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with PWM, DP and zero blanking.
// Define SEG7_BLINK_EN to add the i_blink port and per-digit blinking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV_LOG2 = 15,
    parameter int BLINK_LOG2    = 6
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    cs,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [3:0]              i_bright,
    input  logic                    i_blank_lz,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   i_blink,
`endif
    output logic [7:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_sel
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 16 || SCAN_DIV_LOG2 < 5 || BLINK_LOG2 < 1) begin : g_param_check
        $error("seg7_scan_ctrl: parameter out of legal range");
    end

    logic [SCAN_DIV_LOG2-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]  data_q, data_d;
    logic [NUM_DIGITS-1:0]    dp_q, dp_d;
    logic [7:0]               seg_q, seg_d;
    logic [NUM_DIGITS-1:0]    sel_q, sel_d;

    logic                  tick;
    logic                  last_digit;
    logic [3:0]            phase;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  blink_dark;
    logic                  lit;
    logic [NUM_DIGITS-1:0] blank_mask;

    seg7_lz_blank #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_blank (
        .data_i  (data_q),
        .blank_o (blank_mask)
    );

    // Prescaler, digit index and load latch.
    always_comb begin
        tick       = &cnt_q;
        last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        if (tick) begin
            idx_d = last_digit ? '0 : idx_q + 1'b1;
        end
        data_d = cs ? i_data : data_q;
        dp_d   = cs ? i_dp   : dp_q;
    end

`ifdef SEG7_BLINK_EN
    logic [BLINK_LOG2-1:0] frame_q, frame_d;
    logic                  cur_blink;

    always_comb begin
        frame_d = (tick && last_digit) ? frame_q + 1'b1 : frame_q;
        cur_blink = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_blink = i_blink[k];
            end
        end
        blink_dark = cur_blink & frame_q[BLINK_LOG2-1];
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end
`else
    assign blink_dark = 1'b0;
`endif

    // Phase 0 of every slot is a dark guard so the previous digit cannot ghost.
    assign phase = cnt_q[SCAN_DIV_LOG2-1 -: 4];
    assign lit   = (phase != 4'd0) && (phase <= i_bright) &&
                   !(i_blank_lz && cur_blank) && !blink_dark;

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib   = data_q[4*k +: 4];
                cur_dp    = dp_q[k];
                cur_blank = blank_mask[k];
            end
        end
    end

    always_comb begin
        seg_d = {~cur_dp, hex_to_seg(cur_nib)};
        sel_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (lit && (idx_q == IDX_W'(k))) begin
                sel_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
            dp_q   <= '0;
            seg_q  <= SEG_OFF;
            sel_q  <= '1;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            data_q <= data_d;
            dp_q   <= dp_d;
            seg_q  <= seg_d;
            sel_q  <= sel_d;
        end
    end

    assign o_seg = seg_q;
    assign o_sel = sel_q;

endmodule
